snake_head_stepper: RTL

SNAKE_HEAD_STEPPER -- requirements
Module: snake_head_stepper

---
 rtl/snake_head_stepper.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/snake_head_stepper.sv
// Snake head position stepper: IDLE/RUN/DEAD control, 2-deep turn queue, bounded move per game tick.
// Optional build macro SNAKE_WRAP_EN: wrap around the play field instead of dying at a wall.
module snake_head_stepper #(
  parameter int STEP = 10,
  parameter int X0   = 150,
  parameter int Y0   = 150,
  parameter int XMIN = 10,
  parameter int XMAX = 620,
  parameter int YMIN = 10,
  parameter int YMAX = 460
) (
  input  logic       updateCLK,
  input  logic       reset,
  input  logic [2:0] dir_in,
  input  logic       restart,
  output logic [9:0] head_x,
  output logic [8:0] head_y,
  output logic [1:0] heading,
  output logic       moving,
  output logic       dead,
  output logic       step_strobe,
  output logic [1:0] q_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam logic [1:0] H_UP    = 2'b00;
  localparam logic [1:0] H_LEFT  = 2'b01;
  localparam logic [1:0] H_DOWN  = 2'b10;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMIN_S = 11'(XMIN);
  localparam logic signed [10:0] XMAX_S = 11'(XMAX);
  localparam logic signed [10:0] YMIN_S = 11'(YMIN);
  localparam logic signed [10:0] YMAX_S = 11'(YMAX);

  logic [1:0] state, state_n;
  logic [2:0] last_dir;
  logic [1:0] q0, q1, q0_n, q1_n, cnt_n;
  logic [9:0] head_x_n;
  logic [8:0] head_y_n;
  logic [1:0] heading_n;
  logic       strobe_n;

  logic              key_event, pop, accept, off_field;
  logic [1:0]        key, pop_hd, e0, e1, cnt_p, cmp;
  logic signed [10:0] cur_x, cur_y, nx, ny;

  assign key       = dir_in[1:0];
  assign key_event = !dir_in[2] && (dir_in != last_dir);
  assign moving    = (state == S_RUN);
  assign dead      = (state == S_DEAD);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    pop    = (q_count != 2'd0);
    pop_hd = pop ? q0 : heading;
    cnt_p  = q_count - {1'b0, pop};
    e0     = pop ? q1 : q0;
    e1     = q1;
    // Turns are judged against the last direction the snake will actually be facing.
    cmp    = (cnt_p == 2'd0) ? pop_hd : ((cnt_p == 2'd1) ? e0 : e1);
    accept = key_event && (cnt_p != 2'd2) && (key != cmp) && (key != {~cmp[1], cmp[0]});

    cur_x = $signed({1'b0, head_x});
    cur_y = $signed({2'b00, head_y});
    nx    = cur_x;
    ny    = cur_y;
    case (pop_hd)
      H_UP:    ny = cur_y - STEP_S;
      H_LEFT:  nx = cur_x - STEP_S;
      H_DOWN:  ny = cur_y + STEP_S;
      default: nx = cur_x + STEP_S;
    endcase
    off_field = (nx < XMIN_S) || (nx > XMAX_S) || (ny < YMIN_S) || (ny > YMAX_S);

    state_n   = state;
    head_x_n  = head_x;
    head_y_n  = head_y;
    heading_n = heading;
    q0_n      = q0;
    q1_n      = q1;
    cnt_n     = q_count;
    strobe_n  = 1'b0;

    if (restart) begin
      state_n   = S_IDLE;
      head_x_n  = 10'(X0);
      head_y_n  = 9'(Y0);
      heading_n = H_UP;
      q0_n      = 2'b00;
      q1_n      = 2'b00;
      cnt_n     = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_event) begin
            heading_n = key;
            state_n   = S_RUN;
          end
        end
        S_RUN: begin
          heading_n = pop_hd;
          q0_n      = e0;
          q1_n      = e1;
          cnt_n     = cnt_p;
          if (accept) begin
            if (cnt_p == 2'd0) q0_n = key;
            else               q1_n = key;
            cnt_n = cnt_p + 2'd1;
          end
`ifdef SNAKE_WRAP_EN
          head_x_n = (nx < XMIN_S) ? 10'(XMAX) : (nx > XMAX_S) ? 10'(XMIN) : nx[9:0];
          head_y_n = (ny < YMIN_S) ? 9'(YMAX)  : (ny > YMAX_S) ? 9'(YMIN)  : ny[8:0];
          strobe_n = 1'b1;
`else
          if (off_field) begin
            state_n = S_DEAD;
          end else begin
            head_x_n = nx[9:0];
            head_y_n = ny[8:0];
            strobe_n = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so it sits in the sensitivity list.
  always_ff @(posedge updateCLK or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_dir    <= 3'b111;
      head_x      <= 10'(X0);
      head_y      <= 9'(Y0);
      heading     <= H_UP;
      q0          <= 2'b00;
      q1          <= 2'b00;
      q_count     <= 2'd0;
      step_strobe <= 1'b0;
    end else begin
      state       <= state_n;
      last_dir    <= dir_in;
      head_x      <= head_x_n;
      head_y      <= head_y_n;
      heading     <= heading_n;
      q0          <= q0_n;
      q1          <= q1_n;
      q_count     <= cnt_n;
      step_strobe <= strobe_n;
    end
  end

  // off_field only steers the state in the default build.
  logic unused_ok;
  assign unused_ok = off_field;

endmodule
